// File: rtl/dp_hap_stream_feeder.sv
// Haplotype feeder for the PairHMM PE chain: buffers one haplotype, then drives PE0 with refresh, burst and boundaries.
// Optional feature macro: DP_FEEDER_REPLAY_EN adds i_replay to re-stream the last loaded haplotype.
module dp_hap_stream_feeder #(
    parameter int SCORE_BW    = 16,
    parameter int HAP_MAX_LEN = 1024,
    parameter int LEN_BW      = 11,
    parameter int NUM_PE      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [LEN_BW-1:0]   i_hap_len,
    input  logic                i_hap_valid,
    input  logic [1:0]          i_hap_base,
    output logic                o_hap_ready,
    output logic                o_refresh,
    output logic                o_en,
    output logic [1:0]          o_hap_base,
    output logic [SCORE_BW-1:0] o_A_diag,
    output logic [SCORE_BW-1:0] o_INDEL_diag,
    output logic [SCORE_BW-1:0] o_A_top_add_M2I,
    output logic [SCORE_BW-1:0] o_I_top,
    output logic                o_busy,
    output logic                o_done
`ifdef DP_FEEDER_REPLAY_EN
    ,
    input  logic                i_replay
`endif
);

    localparam int ADDR_BW  = (HAP_MAX_LEN > 1) ? $clog2(HAP_MAX_LEN) : 1;
    localparam int DRAIN_BW = $clog2(NUM_PE + 3);
    localparam logic [SCORE_BW-1:0] MOST_NEG   = {1'b1, {(SCORE_BW-1){1'b0}}};
    localparam logic [LEN_BW-1:0]   MAX_LEN    = LEN_BW'(HAP_MAX_LEN);
    localparam logic [DRAIN_BW-1:0] DRAIN_LAST = DRAIN_BW'(NUM_PE + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REFRESH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_BW-1:0]    len_q, len_d;
    logic [LEN_BW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LEN_BW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DRAIN_BW-1:0]  drain_cnt_q, drain_cnt_d;
    logic                 hap_ready_q, hap_ready_d;
    logic                 refresh_q, refresh_d;
    logic                 en_q, en_d;
    logic [1:0]           hap_base_q, hap_base_d;
    logic [SCORE_BW-1:0]  a_diag_q, a_diag_d;
    logic [SCORE_BW-1:0]  bnd_q, bnd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef DP_FEEDER_REPLAY_EN
    logic                 job_done_q, job_done_d;
`endif

    logic [1:0]           hap_mem [HAP_MAX_LEN];
    logic [LEN_BW-1:0]    len_clamped;
    logic                 wr_en;

    assign len_clamped = (i_hap_len > MAX_LEN) ? MAX_LEN : i_hap_len;
    assign wr_en       = (state_q == S_LOAD) && hap_ready_q && i_hap_valid;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drain_cnt_d = drain_cnt_q;
        hap_ready_d = 1'b0;
        refresh_d   = 1'b0;
        en_d        = 1'b0;
        hap_base_d  = hap_base_q;
        a_diag_d    = MOST_NEG;
        bnd_d       = MOST_NEG;
        done_d      = 1'b0;
`ifdef DP_FEEDER_REPLAY_EN
        job_done_d  = job_done_q;
`endif
        case (state_q)
            S_IDLE: begin
                wr_ptr_d = '0;
                if (i_start) begin
                    len_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d   = S_REFRESH;
                        refresh_d = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        hap_ready_d = 1'b1;
                    end
                end
`ifdef DP_FEEDER_REPLAY_EN
                else if (i_replay && job_done_q) begin
                    state_d   = S_REFRESH;
                    refresh_d = 1'b1;
                end
`endif
            end
            S_LOAD: begin
                hap_ready_d = 1'b1;
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + LEN_BW'(1);
                    // Ready is registered, so it must fall in the same cycle as the last beat lands.
                    if (wr_ptr_q == len_q - LEN_BW'(1)) begin
                        state_d     = S_REFRESH;
                        hap_ready_d = 1'b0;
                        refresh_d   = 1'b1;
                    end
                end
            end
            S_REFRESH: begin
                if (len_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_STREAM;
                    en_d       = 1'b1;
                    hap_base_d = hap_mem[0];
                    a_diag_d   = '0;
                    rd_ptr_d   = LEN_BW'(1);
                end
            end
            S_STREAM: begin
                // rd_ptr_q counts bases already presented; it doubles as the next read address.
                if (rd_ptr_q == len_q) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    en_d       = 1'b1;
                    hap_base_d = hap_mem[rd_ptr_q[ADDR_BW-1:0]];
                    rd_ptr_d   = rd_ptr_q + LEN_BW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_BW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef DP_FEEDER_REPLAY_EN
                job_done_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drain_cnt_q <= '0;
            hap_ready_q <= 1'b0;
            refresh_q   <= 1'b0;
            en_q        <= 1'b0;
            hap_base_q  <= '0;
            a_diag_q    <= MOST_NEG;
            bnd_q       <= MOST_NEG;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DP_FEEDER_REPLAY_EN
            job_done_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drain_cnt_q <= drain_cnt_d;
            hap_ready_q <= hap_ready_d;
            refresh_q   <= refresh_d;
            en_q        <= en_d;
            hap_base_q  <= hap_base_d;
            a_diag_q    <= a_diag_d;
            bnd_q       <= bnd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DP_FEEDER_REPLAY_EN
            job_done_q  <= job_done_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            hap_mem[wr_ptr_q[ADDR_BW-1:0]] <= i_hap_base;
        end
    end

    assign o_hap_ready     = hap_ready_q;
    assign o_refresh       = refresh_q;
    assign o_en            = en_q;
    assign o_hap_base      = hap_base_q;
    assign o_A_diag        = a_diag_q;
    assign o_INDEL_diag    = bnd_q;
    assign o_A_top_add_M2I = bnd_q;
    assign o_I_top         = bnd_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule
